// File: rtl/fetch_predict_stage_pkg.sv
// Shared definitions for the fetch/predict stage: address width and BTB counter encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_predict_stage_pkg;

  // Word-address width of the PC and of instruction memory.
  localparam int IM_ADDR_BIT = 10;

  // Width of the BTB 2-bit saturating direction counter.
  localparam int BTB_CTR_BIT = 2;

  typedef enum logic [BTB_CTR_BIT-1:0] {
    BTB_SNT = 2'b00,  // strongly not taken
    BTB_WNT = 2'b01,  // weakly not taken
    BTB_WT  = 2'b10,  // weakly taken
    BTB_ST  = 2'b11   // strongly taken
  } btb_ctr_e;

  // Saturating step of the direction counter towards the resolved outcome.
  function automatic btb_ctr_e btb_ctr_next(input btb_ctr_e ctr, input logic taken);
    btb_ctr_e res;
    res = ctr;
    if (taken) begin
      if (ctr != BTB_ST) res = btb_ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != BTB_SNT) res = btb_ctr_e'(ctr - 2'd1);
    end
    return res;
  endfunction

  // The counter MSB is the taken prediction.
  function automatic logic btb_ctr_taken(input btb_ctr_e ctr);
    return ctr[BTB_CTR_BIT-1];
  endfunction

endpackage

// File: rtl/fetch_predict_stage_btb_table.sv
// Direct-mapped BTB: valid/tag/target/2-bit counter per entry, one lookup and one update port.
// Latency: lookup combinational from stored state; update visible from the next cycle.
// Backpressure: none; updates are always accepted.
module btb_table
  import fetch_predict_stage_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_BIT,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              lookup_taken_o,
  output logic [ADDR_W-1:0] lookup_target_o,
  input  logic              update_en_i,
  input  logic [ADDR_W-1:0] update_pc_i,
  input  logic [ADDR_W-1:0] update_target_i,
  input  logic              update_taken_i
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  btb_ctr_e          ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lu_idx;
  logic [TAG_W-1:0] lu_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  btb_ctr_e         up_ctr_d;

  assign lu_idx = lookup_pc_i[IDX_W-1:0];
  assign lu_tag = lookup_pc_i[ADDR_W-1:IDX_W];
  assign up_idx = update_pc_i[IDX_W-1:0];
  assign up_tag = update_pc_i[ADDR_W-1:IDX_W];

  // Lookup reads registered contents only, so a same-cycle update is not visible yet.
  always_comb begin
    lookup_taken_o  = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag) && btb_ctr_taken(ctr_q[lu_idx]);
    lookup_target_o = target_q[lu_idx];
  end

  // Training decision for the indexed entry: strengthen/weaken on a hit, allocate weak-taken on a taken miss.
  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr_d = up_hit ? btb_ctr_next(ctr_q[up_idx], update_taken_i) : BTB_WT;
  end

  // Entry storage; a not-taken miss leaves the entry untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BTB_SNT;
      end
    end else if (update_en_i && (up_hit || update_taken_i)) begin
      ctr_q[up_idx] <= up_ctr_d;
      if (update_taken_i) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target_i;
      end
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// Fetch stage: PC register, next-PC prediction (BTB when FETCH_BTB_EN is defined, else PC+1), IF/ID register.
// Latency: inst_addr is the PC combinationally; IF/ID outputs one edge after inst_in is sampled.
// Backpressure: en=0 stalls PC and IF/ID; redirect overrides the stall; clear/redirect insert a bubble.
module fetch_predict_stage
  import fetch_predict_stage_pkg::*;
#(
  parameter int                ADDR_W    = IM_ADDR_BIT,
  parameter int                BTB_IDX_W = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              update_en,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_taken,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_in,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc_4,
  output logic [ADDR_W-1:0] pc_guessed
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] guess;
  logic              btb_taken;
  logic [ADDR_W-1:0] btb_target;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] pc4_q;
  logic [ADDR_W-1:0] guess_q;

  assign pc_plus1  = pc_q + 1'b1;
  assign inst_addr = pc_q;

`ifdef FETCH_BTB_EN
  btb_table #(
    .ADDR_W (ADDR_W),
    .IDX_W  (BTB_IDX_W)
  ) u_btb (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc_i     (pc_q),
    .lookup_taken_o  (btb_taken),
    .lookup_target_o (btb_target),
    .update_en_i     (update_en),
    .update_pc_i     (update_pc),
    .update_target_i (update_target),
    .update_taken_i  (update_taken)
  );
`else
  // Without a BTB the training port is accepted but has no effect.
  logic unused_update;
  assign unused_update = ^{update_en, update_pc, update_target, update_taken};
  assign btb_taken     = 1'b0;
  assign btb_target    = '0;
`endif

  // Next-PC selection: redirect wins even during a stall, otherwise advance to the prediction.
  always_comb begin
    guess = btb_taken ? btb_target : pc_plus1;
    pc_d  = pc_q;
    if (redirect_en)  pc_d = redirect_pc;
    else if (en)      pc_d = guess;
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // IF/ID register: bubble on clear or redirect, capture on enable, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= '0;
      pc4_q   <= '0;
      guess_q <= '0;
    end else if (clear || redirect_en) begin
      inst_q  <= '0;
      pc4_q   <= '0;
      guess_q <= '0;
    end else if (en) begin
      inst_q  <= inst_in;
      pc4_q   <= pc_plus1;
      guess_q <= guess;
    end
  end

  assign inst       = inst_q;
  assign pc_4       = pc4_q;
  assign pc_guessed = guess_q;

endmodule

// File: tb/tb_fetch_predict_stage.sv
module tb_fetch_predict_stage;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, clear = 1'b0, redirect_en = 1'b0, update_en = 1'b0, update_taken = 1'b0;
  logic [9:0]  redirect_pc = '0, update_pc = '0, update_target = '0;
  logic [9:0]  inst_addr, pc_4, pc_guessed;
  logic [31:0] inst_in, inst;

  int total = 0;
  int bad   = 0;

  // Reference state: plain integers, addresses modulo 1024.
  int          m_pc, m_pc4, m_guess;
  logic [31:0] m_inst;
  int          bv[16], btag[16], btgt[16], bctr[16];

  fetch_predict_stage #(
    .ADDR_W    (10),
    .BTB_IDX_W (4),
    .RESET_PC  (10'h010)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .clear         (clear),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .inst_addr     (inst_addr),
    .inst_in       (inst_in),
    .inst          (inst),
    .pc_4          (pc_4),
    .pc_guessed    (pc_guessed)
  );

  always #5 clk = ~clk;

  // Instruction memory content is a simple function of the address.
  assign inst_in = 32'hC0DE_0000 | {22'h0, inst_addr};

  function automatic logic [31:0] mem_word(input int pc);
    return 32'hC0DE_0000 | 32'(pc);
  endfunction

  function automatic int m_predict(input int pc);
    int i;
    i = pc % 16;
    if (BTB_ON && bv[i] != 0 && btag[i] == pc / 16 && bctr[i] >= 2) return btgt[i];
    return (pc + 1) % 1024;
  endfunction

  task automatic model_reset();
    m_pc = 16; m_pc4 = 0; m_guess = 0; m_inst = '0;
    for (int i = 0; i < 16; i++) begin
      bv[i] = 0; btag[i] = 0; btgt[i] = 0; bctr[i] = 0;
    end
  endtask

  task automatic model_edge();
    int g, i;
    g = m_predict(m_pc);
    if (clear || redirect_en) begin
      m_inst = '0; m_pc4 = 0; m_guess = 0;
    end else if (en) begin
      m_inst = mem_word(m_pc); m_pc4 = (m_pc + 1) % 1024; m_guess = g;
    end
    if (redirect_en) m_pc = int'(redirect_pc);
    else if (en)     m_pc = g;
    if (BTB_ON && update_en) begin
      i = int'(update_pc) % 16;
      if (bv[i] != 0 && btag[i] == int'(update_pc) / 16) begin
        if (update_taken) begin
          bctr[i] = (bctr[i] < 3) ? bctr[i] + 1 : 3;
          btgt[i] = int'(update_target);
        end else begin
          bctr[i] = (bctr[i] > 0) ? bctr[i] - 1 : 0;
        end
      end else if (update_taken) begin
        bv[i] = 1; btag[i] = int'(update_pc) / 16; btgt[i] = int'(update_target); bctr[i] = 2;
      end
    end
  endtask

  task automatic idle();
    en = 0; clear = 0; redirect_en = 0; update_en = 0; update_taken = 0;
    redirect_pc = '0; update_pc = '0; update_target = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input int pc, input int tgt, input bit taken);
    idle();
    update_en = 1; update_pc = 10'(pc); update_target = 10'(tgt); update_taken = taken;
    tick();
    idle();
  endtask

  // Redirect to pc, then fetch it once; IF/ID then holds that fetch.
  task automatic fetch_at(input int pc);
    idle();
    redirect_en = 1; redirect_pc = 10'(pc);
    tick();
    idle();
    en = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    total++; if (inst_addr !== 10'h010) begin bad++; $display("FAIL reset_pc got=%h exp=010", inst_addr); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
    total++; if (pc_4 !== 10'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", pc_4); end
    total++; if (pc_guessed !== 10'h0) begin bad++; $display("FAIL reset_guess got=%h exp=0", pc_guessed); end
    rst = 0;
  endtask

  task automatic test_freerun();
    idle();
    en = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL freerun_pc%0d got=%h exp=%h", k, inst_addr, 10'(m_pc)); end
      total++; if (pc_4 !== 10'(m_pc4)) begin bad++; $display("FAIL freerun_pc4_%0d got=%h exp=%h", k, pc_4, 10'(m_pc4)); end
    end
    idle();
  endtask

  task automatic test_training();
    train(32'h20, 32'h40, 1'b1);
    fetch_at(32'h20);
    total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL train_guess got=%h exp=%h", pc_guessed, 10'(m_guess)); end
    total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL train_next_pc got=%h exp=%h", inst_addr, 10'(m_pc)); end
    total++; if (inst !== m_inst) begin bad++; $display("FAIL train_inst got=%h exp=%h", inst, m_inst); end
    train(32'h20, 32'h40, 1'b0);
    fetch_at(32'h20);
    total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL weaken_guess got=%h exp=%h", pc_guessed, 10'(m_guess)); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) train(32'h30, 32'h50, 1'b1);
    train(32'h30, 32'h50, 1'b0);
    fetch_at(32'h30);
    total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL sat_guess got=%h exp=%h", pc_guessed, 10'(m_guess)); end
    total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL sat_next_pc got=%h exp=%h", inst_addr, 10'(m_pc)); end
  endtask

  task automatic test_redirect_stall();
    idle(); en = 1; tick();
    idle(); redirect_en = 1; redirect_pc = 10'h055; tick();
    idle();
    total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL rstall_pc got=%h exp=%h", inst_addr, 10'(m_pc)); end
    total++; if (inst !== m_inst) begin bad++; $display("FAIL rstall_inst got=%h exp=%h", inst, m_inst); end
    total++; if (pc_4 !== 10'(m_pc4)) begin bad++; $display("FAIL rstall_pc4 got=%h exp=%h", pc_4, 10'(m_pc4)); end
    total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL rstall_guess got=%h exp=%h", pc_guessed, 10'(m_guess)); end
  endtask

  task automatic test_clear_and_hold();
    idle(); en = 1; clear = 1; tick();
    total++; if (inst !== m_inst) begin bad++; $display("FAIL clear_inst got=%h exp=%h", inst, m_inst); end
    total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL clear_pc got=%h exp=%h", inst_addr, 10'(m_pc)); end
    idle(); en = 1; tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL hold_pc%0d got=%h exp=%h", k, inst_addr, 10'(m_pc)); end
      total++; if (inst !== m_inst) begin bad++; $display("FAIL hold_inst%0d got=%h exp=%h", k, inst, m_inst); end
      total++; if (pc_4 !== 10'(m_pc4)) begin bad++; $display("FAIL hold_pc4_%0d got=%h exp=%h", k, pc_4, 10'(m_pc4)); end
      total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL hold_guess%0d got=%h exp=%h", k, pc_guessed, 10'(m_guess)); end
    end
  endtask

  task automatic test_alias_wrap();
    train(32'h03, 32'h70, 1'b1);
    train(32'h13, 32'h80, 1'b1);
    fetch_at(32'h03);
    total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL alias_old got=%h exp=%h", pc_guessed, 10'(m_guess)); end
    fetch_at(32'h13);
    total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL alias_new got=%h exp=%h", pc_guessed, 10'(m_guess)); end
    fetch_at(32'h3FF);
    total++; if (pc_4 !== 10'(m_pc4)) begin bad++; $display("FAIL wrap_pc4 got=%h exp=%h", pc_4, 10'(m_pc4)); end
    total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", inst_addr, 10'(m_pc)); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      idle();
      en           = ($urandom_range(0, 3) != 0);
      clear        = ($urandom_range(0, 7) == 0);
      redirect_en  = ($urandom_range(0, 7) == 0);
      redirect_pc  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1008, 1023)) : 10'($urandom_range(0, 63));
      update_en    = ($urandom_range(0, 2) == 0);
      update_pc    = ($urandom_range(0, 1) == 0) ? 10'(m_pc) : 10'($urandom_range(0, 63));
      update_target = 10'($urandom_range(0, 63));
      update_taken = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (inst_addr !== 10'(m_pc)) begin bad++; $display("FAIL rnd_pc c%0d got=%h exp=%h", k, inst_addr, 10'(m_pc)); end
      total++; if (inst !== m_inst) begin bad++; $display("FAIL rnd_inst c%0d got=%h exp=%h", k, inst, m_inst); end
      total++; if (pc_4 !== 10'(m_pc4)) begin bad++; $display("FAIL rnd_pc4 c%0d got=%h exp=%h", k, pc_4, 10'(m_pc4)); end
      total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL rnd_guess c%0d got=%h exp=%h", k, pc_guessed, 10'(m_guess)); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    train(32'h25, 32'h60, 1'b1);
    idle(); en = 1; tick();
    idle();
    redirect_en = 1; redirect_pc = 10'h077; update_en = 1; update_pc = 10'h025;
    update_target = 10'h061; update_taken = 1;
    #2;
    rst = 1;
    #1;
    model_reset();
    total++; if (inst_addr !== 10'h010) begin bad++; $display("FAIL midrst_pc got=%h exp=010", inst_addr); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL midrst_inst got=%h exp=0", inst); end
    @(posedge clk); #1;
    rst = 0;
    idle();
    fetch_at(32'h25);
    total++; if (pc_guessed !== 10'(m_guess)) begin bad++; $display("FAIL midrst_btb got=%h exp=%h", pc_guessed, 10'(m_guess)); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_freerun();
    test_training();
    test_saturation();
    test_redirect_stall();
    test_clear_and_hold();
    test_alias_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
